tdm_frame_demux: RTL and testbench
==================================

Name: tdm_frame_demux

Overview:
- Receive-side counterpart of the round-robin TDM mux/DSP path.
- Takes one time-multiplexed sample stream (one channel per valid beat, channel 0 marked by a start-of-frame strobe) and rebuilds a coherent per-channel output frame.
- Checks frame alignment against the start-of-frame marker and counts alignment errors.
- Sits directly after the DSP product register, in the fast (TDM) clock domain.

Parameters:
- DATA_WIDTH, 16: width of each TDM sample and of each channel output.
- NUM_CHANNELS, 2: channels per TDM frame; must be ≥2.
- ERR_WIDTH, 8: width of the saturating alignment-error counter.

Ports:
- clk  input  1  TDM clock; all logic rising-edge.
- rst  input  1  asynchronous, active-low reset (assert low; deassert synchronously to clk upstream).
- din  input  DATA_WIDTH  TDM sample stream.
- din_valid  input  1  din carries a sample this cycle.
- sof  input  1  din is channel 0 of a frame; ignored when din_valid=0.
- dout  output  NUM_CHANNELS x DATA_WIDTH  last complete frame, one word per channel.
- frame_valid  output  1  one-cycle pulse: dout updated with a new complete frame.
- locked  output  1  alignment acquired (first sof seen since reset).
- sync_err  output  1  one-cycle pulse: misaligned sof detected.
- err_count  output  ERR_WIDTH  saturating count of sync_err events.

Behaviour:
- Reset (rst=0, asynchronous): slot counter=0, locked=0, staging regs=0, dout=0, frame_valid=0, sync_err=0, err_count=0.
- State:
  - UNLOCKED: all beats without sof are discarded.
  - LOCKED: beats are accepted in order.
- Slot counter: 0..NUM_CHANNELS-1.
  - Advances only on an accepted beat (din_valid=1).
  - din_valid=0 is a stall: counter and staging registers hold, with no timeout.
- UNLOCKED → LOCKED: on the first din_valid & sof.
  - That beat is stored as slot 0 and the counter goes to 1.
  - locked rises the next cycle and stays high until reset.
- LOCKED, din_valid=1, sof=0, counter=k: stage[k] ← din; counter ← k+1, wrapping to 0 after NUM_CHANNELS-1.
- LOCKED, din_valid=1, sof=1, counter=0: normal frame start; stage[0] ← din, counter ← 1.
- LOCKED, din_valid=1, sof=1, counter≠0 (early or late marker):
  - sync_err pulses the next cycle.
  - err_count increments, saturating at all-ones.
  - The partial frame is discarded; no frame_valid for it.
  - stage[0] ← din, counter ← 1 (realign on the marker).
- Beat at slot NUM_CHANNELS-1 with sof=0 completes a frame. On the next cycle:
  - all dout[i] ← stage[i] for i<NUM_CHANNELS-1;
  - dout[NUM_CHANNELS-1] ← the completing din;
  - frame_valid pulses for one cycle;
  - counter ← 0.
- Latency: completing beat at edge n → dout/frame_valid visible after edge n+1.
- dout changes only on frame_valid and holds otherwise; all channels are updated in the same cycle, so the frame is always coherent.
- Back-to-back frames are supported at full rate: frame_valid may pulse once every NUM_CHANNELS cycles with no bubble.
- A sof on the completing slot (counter=NUM_CHANNELS-1) is a misalignment: apply the sync_err rule and produce no frame_valid.
- Reset mid-frame: all state clears immediately; a new sof is required to relock.

Test Plan:
- Reset, then no sof; drive din_valid=1 with din=0x1111,0x2222 → locked=0, frame_valid never pulses, dout=0.
- NUM_CHANNELS=2: sof+0x00AA, then 0x00BB, then sof+0x00CC, then 0x00DD →
  - frame_valid pulses 1 cycle after 0x00BB: dout[0]=0x00AA, dout[1]=0x00BB;
  - second pulse exactly 2 cycles later: dout[0]=0x00CC, dout[1]=0x00DD;
  - sync_err never pulses.
- Stall: sof+0x0010, din_valid=0 for 5 cycles, then 0x0020 → single frame_valid 1 cycle after 0x0020; dout={0x0010,0x0020}; no error.
- Misalign, NUM_CHANNELS=4: sof+A, B, sof+C, D, E, F →
  - sync_err pulse 1 cycle after C, err_count=1;
  - no frame for A/B;
  - frame_valid after F with dout={C,D,E,F}.
- Saturation (ERR_WIDTH=8): force 300 misaligned sof events → err_count stops at 0xFF; sync_err still pulses on every event.
- Assert rst low asynchronously mid-frame (between clock edges) → all outputs zero immediately; after release, the next frame requires a new sof to relock.

Source files
------------

// File: rtl/tdm_frame_demux.sv
// tdm_frame_demux
// Rebuilds a coherent per-channel frame from a round-robin TDM sample stream.
// Channel 0 of every frame is marked by a start-of-frame strobe. The block
// locks on the first marker and realigns on any marker that shows up away
// from slot 0. Every realignment is counted in a saturating error counter.
// All outputs are registered: a beat sampled on a rising edge affects the
// outputs right after that same edge.

module tdm_frame_demux #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int ERR_WIDTH    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH-1:0]                  din,
  input  logic                                   din_valid,
  input  logic                                   sof,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] dout,
  output logic                                   frame_valid,
  output logic                                   locked,
  output logic                                   sync_err,
  output logic [ERR_WIDTH-1:0]                   err_count
);

  localparam int CNT_W = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CHANNELS - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                              r_state;
  state_t                              w_nextState;
  logic [CNT_W-1:0]                    r_slotCnt;
  logic [DATA_WIDTH-1:0]               r_stage [0:NUM_CHANNELS-2];
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_dout;
  logic                                r_frameValid;
  logic                                r_syncErr;
  logic [ERR_WIDTH-1:0]                r_errCount;

  // Decoded actions for the current beat.
  logic                                w_start;
  logic                                w_store;
  logic                                w_complete;
  logic                                w_err;

  // State register: stays LOCKED once the first marker has been seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= UNLOCKED;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and beat classification: frame start, mid-frame store,
  // frame completion, or a marker that arrived away from slot 0.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_complete  = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (din_valid && sof) begin
          w_nextState = LOCKED;
          w_start     = 1'b1;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (sof) begin
            w_start = 1'b1;
            w_err   = (r_slotCnt != '0);
          end else if (r_slotCnt == LAST_SLOT) begin
            w_complete = 1'b1;
          end else begin
            w_store = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = UNLOCKED;
      end
    endcase
  end

  // Slot counter: a marker always restarts at slot 1, completion wraps to 0,
  // a stall (din_valid low) leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slotCnt <= '0;
    end else if (w_start) begin
      r_slotCnt <= CNT_W'(1);
    end else if (w_complete) begin
      r_slotCnt <= '0;
    end else if (w_store) begin
      r_slotCnt <= r_slotCnt + CNT_W'(1);
    end
  end

  // Staging registers for every slot but the last; the last slot is taken
  // straight from din when the frame completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
        if ((w_start && (i == 0)) || (w_store && (r_slotCnt == CNT_W'(i)))) begin
          r_stage[i] <= din;
        end
      end
    end
  end

  // Output frame: all channels load together so a reader never sees a mix
  // of two frames; frame_valid marks the single cycle of that load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout       <= '0;
      r_frameValid <= 1'b0;
    end else begin
      r_frameValid <= w_complete;
      if (w_complete) begin
        for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
          r_dout[i] <= r_stage[i];
        end
        r_dout[NUM_CHANNELS-1] <= din;
      end
    end
  end

  // Misalignment pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_syncErr  <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_syncErr <= w_err;
      if (w_err && (r_errCount != '1)) begin
        r_errCount <= r_errCount + ERR_WIDTH'(1);
      end
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frameValid;
  assign locked      = (r_state == LOCKED);
  assign sync_err    = r_syncErr;
  assign err_count   = r_errCount;

endmodule

// File: tb/tb_tdm_frame_demux.sv
// Testbench for tdm_frame_demux: a 2-channel and a 4-channel instance see the
// same input stream. A queue-based frame model predicts both every cycle;
// table vectors and hand sequences add fixed expectations from the test plan.

module tb_tdm_frame_demux;

  logic                  clk;
  logic                  rst;
  logic [15:0]           din;
  logic                  din_valid;
  logic                  sof;

  logic [1:0][15:0]      dout2;
  logic                  fv2, lk2, se2;
  logic [7:0]            ec2;
  logic [3:0][15:0]      dout4;
  logic                  fv4, lk4, se4;
  logic [7:0]            ec4;

  int assertCount = 0;
  int failCount   = 0;

  tdm_frame_demux #(.DATA_WIDTH(16), .NUM_CHANNELS(2), .ERR_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout2), .frame_valid(fv2), .locked(lk2), .sync_err(se2), .err_count(ec2)
  );

  tdm_frame_demux #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .ERR_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout4), .frame_valid(fv4), .locked(lk4), .sync_err(se4), .err_count(ec4)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: per instance, a queue of beats gathered for the current
  // frame; a frame is emitted once the queue holds NUM_CHANNELS beats.
  bit          mLocked [2];
  bit          mFv     [2];
  bit          mErr    [2];
  int          mEc     [2];
  logic [15:0] mDout   [2][4];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mLocked[m] = 0; mFv[m] = 0; mErr[m] = 0; mEc[m] = 0;
      for (int i = 0; i < 4; i++) mDout[m][i] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic modelStep(input bit v, input bit s, input logic [15:0] d);
    for (int m = 0; m < 2; m++) begin
      logic [15:0] part [$];
      int n;
      n = (m == 0) ? 2 : 4;
      if (m == 0) part = q0; else part = q1;
      mFv[m]  = 0;
      mErr[m] = 0;
      if (v) begin
        if (!mLocked[m]) begin
          if (s) begin
            mLocked[m] = 1;
            part.delete();
            part.push_back(d);
          end
        end else if (s) begin
          if (part.size() != 0) begin
            mErr[m] = 1;
            if (mEc[m] < 255) mEc[m]++;
          end
          part.delete();
          part.push_back(d);
        end else begin
          part.push_back(d);
          if (part.size() == n) begin
            for (int i = 0; i < n; i++) mDout[m][i] = part[i];
            mFv[m] = 1;
            part.delete();
          end
        end
      end
      if (m == 0) q0 = part; else q1 = part;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model.
  task automatic checkOutput();
    logic [63:0] e2, e4;
    e2 = {32'h0, mDout[0][1], mDout[0][0]};
    e4 = {mDout[1][3], mDout[1][2], mDout[1][1], mDout[1][0]};
    chk("model fv2",   64'(fv2),   64'(mFv[0]));
    chk("model err2",  64'(se2),   64'(mErr[0]));
    chk("model lock2", 64'(lk2),   64'(mLocked[0]));
    chk("model ecnt2", 64'(ec2),   64'(mEc[0]));
    chk("model dout2", 64'(dout2), e2);
    chk("model fv4",   64'(fv4),   64'(mFv[1]));
    chk("model err4",  64'(se4),   64'(mErr[1]));
    chk("model lock4", 64'(lk4),   64'(mLocked[1]));
    chk("model ecnt4", 64'(ec4),   64'(mEc[1]));
    chk("model dout4", 64'(dout4), e4);
  endtask

  // Drive one beat just after an edge, step the model at the next edge and
  // compare shortly afterwards.
  task automatic applyStimulus(input bit v, input bit s, input logic [15:0] d);
    din       = d;
    din_valid = v;
    sof       = s;
    @(posedge clk);
    modelStep(v, s, d);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic doReset();
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    chk("rst dout2", 64'(dout2), 64'h0);
    chk("rst fv2",   64'(fv2),   64'h0);
    chk("rst lock2", 64'(lk2),   64'h0);
    chk("rst err2",  64'(se2),   64'h0);
    chk("rst ecnt2", 64'(ec2),   64'h0);
    chk("rst dout4", 64'(dout4), 64'h0);
    chk("rst lock4", 64'(lk4),   64'h0);
    chk("rst ecnt4", 64'(ec4),   64'h0);
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic        doRst;
    logic        v;
    logic        s;
    logic [15:0] d;
    logic        sel;
    logic        expFv;
    logic        expErr;
    logic        expLock;
    logic [7:0]  expEc;
    logic [63:0] expDout;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [15:0] d, input logic sel,
                              input logic fv, input logic er, input logic lk,
                              input logic [7:0] ec, input logic [63:0] dd);
    vec_t t;
    t.doRst = r; t.v = v; t.s = s; t.d = d; t.sel = sel;
    t.expFv = fv; t.expErr = er; t.expLock = lk; t.expEc = ec; t.expDout = dd;
    return t;
  endfunction

  vec_t tab [25];

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 2-channel: no marker, clean frames, stall.  4-channel: misalignment.
    tab[0]  = mk(1, 1, 0, 16'h1111, 0, 0, 0, 0, 0, 64'h0);
    tab[1]  = mk(0, 1, 0, 16'h2222, 0, 0, 0, 0, 0, 64'h0);
    tab[2]  = mk(0, 1, 1, 16'h00AA, 0, 0, 0, 1, 0, 64'h0);
    tab[3]  = mk(0, 1, 0, 16'h00BB, 0, 1, 0, 1, 0, 64'h00BB_00AA);
    tab[4]  = mk(0, 1, 1, 16'h00CC, 0, 0, 0, 1, 0, 64'h00BB_00AA);
    tab[5]  = mk(0, 1, 0, 16'h00DD, 0, 1, 0, 1, 0, 64'h00DD_00CC);
    tab[6]  = mk(0, 1, 1, 16'h0010, 0, 0, 0, 1, 0, 64'h00DD_00CC);
    tab[7]  = mk(0, 0, 0, 16'h5555, 0, 0, 0, 1, 0, 64'h00DD_00CC);
    tab[8]  = mk(0, 0, 1, 16'h6666, 0, 0, 0, 1, 0, 64'h00DD_00CC);
    tab[9]  = mk(0, 0, 0, 16'h7777, 0, 0, 0, 1, 0, 64'h00DD_00CC);
    tab[10] = mk(0, 0, 1, 16'h8888, 0, 0, 0, 1, 0, 64'h00DD_00CC);
    tab[11] = mk(0, 0, 0, 16'h9999, 0, 0, 0, 1, 0, 64'h00DD_00CC);
    tab[12] = mk(0, 1, 0, 16'h0020, 0, 1, 0, 1, 0, 64'h0020_0010);
    tab[13] = mk(1, 1, 1, 16'h0A0A, 1, 0, 0, 1, 0, 64'h0);
    tab[14] = mk(0, 1, 0, 16'h0B0B, 1, 0, 0, 1, 0, 64'h0);
    tab[15] = mk(0, 1, 1, 16'h0C0C, 1, 0, 1, 1, 1, 64'h0);
    tab[16] = mk(0, 1, 0, 16'h0D0D, 1, 0, 0, 1, 1, 64'h0);
    tab[17] = mk(0, 1, 0, 16'h0E0E, 1, 0, 0, 1, 1, 64'h0);
    tab[18] = mk(0, 1, 0, 16'h0F0F, 1, 1, 0, 1, 1, 64'h0F0F_0E0E_0D0D_0C0C);
    // Late marker on the completing slot of the 4-channel instance.
    tab[19] = mk(0, 1, 1, 16'h1001, 1, 0, 0, 1, 1, 64'h0F0F_0E0E_0D0D_0C0C);
    tab[20] = mk(0, 1, 0, 16'h1002, 1, 0, 0, 1, 1, 64'h0F0F_0E0E_0D0D_0C0C);
    tab[21] = mk(0, 1, 0, 16'h1003, 1, 0, 0, 1, 1, 64'h0F0F_0E0E_0D0D_0C0C);
    tab[22] = mk(0, 1, 1, 16'h1004, 1, 0, 1, 1, 2, 64'h0F0F_0E0E_0D0D_0C0C);
    tab[23] = mk(0, 1, 0, 16'h1005, 1, 0, 0, 1, 2, 64'h0F0F_0E0E_0D0D_0C0C);
    tab[24] = mk(0, 0, 0, 16'h1006, 1, 0, 0, 1, 2, 64'h0F0F_0E0E_0D0D_0C0C);

    for (int i = 0; i < 25; i++) begin
      if (tab[i].doRst) doReset();
      applyStimulus(tab[i].v, tab[i].s, tab[i].d);
      if (tab[i].sel == 1'b0) begin
        chk($sformatf("vec%0d fv2", i),   64'(fv2),   64'(tab[i].expFv));
        chk($sformatf("vec%0d err2", i),  64'(se2),   64'(tab[i].expErr));
        chk($sformatf("vec%0d lock2", i), 64'(lk2),   64'(tab[i].expLock));
        chk($sformatf("vec%0d ecnt2", i), 64'(ec2),   64'(tab[i].expEc));
        chk($sformatf("vec%0d dout2", i), 64'(dout2), tab[i].expDout);
      end else begin
        chk($sformatf("vec%0d fv4", i),   64'(fv4),   64'(tab[i].expFv));
        chk($sformatf("vec%0d err4", i),  64'(se4),   64'(tab[i].expErr));
        chk($sformatf("vec%0d lock4", i), 64'(lk4),   64'(tab[i].expLock));
        chk($sformatf("vec%0d ecnt4", i), 64'(ec4),   64'(tab[i].expEc));
        chk($sformatf("vec%0d dout4", i), 64'(dout4), tab[i].expDout);
      end
    end

    // Saturation: one aligning marker, then 300 markers each landing on slot 1.
    applyStimulus(1, 1, 16'h4000);
    applyStimulus(1, 0, 16'h4001);
    applyStimulus(1, 1, 16'h4002);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 16'(16'h5000 + i));
      chk($sformatf("sat%0d err4", i), 64'(se4), 64'h1);
      chk($sformatf("sat%0d err2", i), 64'(se2), 64'h1);
    end
    chk("sat ecnt4", 64'(ec4), 64'hFF);
    chk("sat ecnt2", 64'(ec2), 64'hFF);

    // Mid-frame asynchronous reset, then relock only on a new marker.
    applyStimulus(1, 1, 16'h6001);
    applyStimulus(1, 0, 16'h6002);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 16'h1234);
      chk($sformatf("relock%0d lock2", i), 64'(lk2), 64'h0);
      chk($sformatf("relock%0d fv2", i),   64'(fv2), 64'h0);
      chk($sformatf("relock%0d lock4", i), 64'(lk4), 64'h0);
    end
    applyStimulus(1, 1, 16'h7001);
    chk("relock lock4", 64'(lk4), 64'h1);
    applyStimulus(1, 0, 16'h7002);
    chk("relock fv2", 64'(fv2), 64'h1);
    chk("relock dout2", 64'(dout2), 64'h7002_7001);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 4) == 0);
      applyStimulus(v, s, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
